// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings and sizing defaults for the pipelined integer ALU.
package alu_pipe_pkg;

  localparam int ALU_OPW           = 4;
  localparam int ALU_WIDTH_DEFAULT = 64;

  typedef enum logic [ALU_OPW-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SRL   = 4'd3,
    ALU_SRA   = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_OR    = 4'd6,
    ALU_AND   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

endpackage

// File: rtl/alu_pipe_core.sv
// Purely combinational ALU datapath: full-width and 32-bit word results with carry/overflow.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH    = ALU_WIDTH_DEFAULT,
  parameter int HAS_WORD = 1
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [ALU_OPW-1:0] op,
  input  logic               cin,
  input  logic               word,
  output logic [WIDTH-1:0]   c,
  output logic               cout,
  output logic               ovf
);

  localparam int SHW = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] sext32(input logic [31:0] v);
    return WIDTH'($signed(v));
  endfunction

  logic             word_en;
  logic             is_sub;
  logic             carry_in;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum_f;
  logic [32:0]      sum_w;
  logic             ovf_f;
  logic             ovf_w;
  logic [SHW-1:0]   sh_f;
  logic [4:0]       sh_w;
  logic [31:0]      a_w;
  logic [31:0]      b_w;
  logic [31:0]      r_w;
  logic [WIDTH-1:0] r_f;

  // Word mode only exists on a 64-bit datapath.
  assign word_en  = (HAS_WORD != 0) && (WIDTH == 64) && word;
  assign is_sub   = (op == ALU_SUB);
  assign carry_in = is_sub || ((op == ALU_ADD) && cin);
  assign b_op     = is_sub ? ~b : b;
  assign a_w      = a[31:0];
  assign b_w      = b[31:0];
  assign sh_f     = b[SHW-1:0];
  assign sh_w     = b[4:0];

  // One shared adder per width; SUB is a + ~b + 1, so cout=1 means no borrow.
  assign sum_f = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, carry_in};
  assign sum_w = {1'b0, a_w} + {1'b0, b_op[31:0]} + {32'd0, carry_in};
  assign ovf_f = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum_f[WIDTH-1] != a[WIDTH-1]);
  assign ovf_w = (a_w[31] == b_op[31]) && (sum_w[31] != a_w[31]);

  always_comb begin
    r_f = '0;
    case (op)
      ALU_ADD, ALU_SUB: r_f = sum_f[WIDTH-1:0];
      ALU_SLL:          r_f = a << sh_f;
      ALU_SRL:          r_f = a >> sh_f;
      ALU_SRA:          r_f = $unsigned($signed(a) >>> sh_f);
      ALU_XOR:          r_f = a ^ b;
      ALU_OR:           r_f = a | b;
      ALU_AND:          r_f = a & b;
      ALU_SLT:          r_f = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:         r_f = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_PASSB:        r_f = b;
      default:          r_f = '0;
    endcase
  end

  always_comb begin
    r_w = '0;
    case (op)
      ALU_ADD, ALU_SUB: r_w = sum_w[31:0];
      ALU_SLL:          r_w = a_w << sh_w;
      ALU_SRL:          r_w = a_w >> sh_w;
      ALU_SRA:          r_w = $unsigned($signed(a_w) >>> sh_w);
      ALU_XOR:          r_w = a_w ^ b_w;
      ALU_OR:           r_w = a_w | b_w;
      ALU_AND:          r_w = a_w & b_w;
      ALU_SLT:          r_w = {31'd0, ($signed(a_w) < $signed(b_w))};
      ALU_SLTU:         r_w = {31'd0, (a_w < b_w)};
      ALU_PASSB:        r_w = b_w;
      default:          r_w = '0;
    endcase
  end

  always_comb begin
    c    = word_en ? sext32(r_w) : r_f;
    cout = 1'b0;
    ovf  = 1'b0;
    if ((op == ALU_ADD) || is_sub) begin
      cout = word_en ? sum_w[32] : sum_f[WIDTH];
      ovf  = word_en ? ovf_w : ovf_f;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined integer ALU: combinational core followed by a STAGES-deep valid/ready slot chain.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH    = ALU_WIDTH_DEFAULT,
  parameter int STAGES   = 1,
  parameter int HAS_WORD = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [ALU_OPW-1:0] in_op,
  input  logic               in_cin,
  input  logic               in_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_c,
  output logic               out_cout,
  output logic               out_ovf,
  output logic               out_zero
);

  logic [WIDTH-1:0]  core_c;
  logic              core_cout;
  logic              core_ovf;

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic              hole;
  logic [WIDTH-1:0]  c_p     [STAGES];
  logic [WIDTH-1:0]  src_c   [STAGES];
  logic [STAGES-1:0] cout_p;
  logic [STAGES-1:0] ovf_p;
  logic [STAGES-1:0] src_cout;
  logic [STAGES-1:0] src_ovf;

  alu_core #(
    .WIDTH    (WIDTH),
    .HAS_WORD (HAS_WORD)
  ) u_core (
    .a    (in_a),
    .b    (in_b),
    .op   (in_op),
    .cin  (in_cin),
    .word (in_word),
    .c    (core_c),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  // A slot advances when any later slot is empty or the consumer takes the last one.
  always_comb begin
    hole     = 1'b0;
    adv      = '0;
    load     = '0;
    src_cout = '0;
    src_ovf  = '0;
    for (int k = 0; k < STAGES; k++) begin
      hole = out_ready;
      for (int j = k + 1; j < STAGES; j++) begin
        hole = hole || !vld_p[j];
      end
      adv[k]   = vld_p[k] && hole;
      src_c[k] = '0;
    end
    in_ready    = !vld_p[0] || adv[0];
    load[0]     = in_valid && in_ready && !flush;
    src_c[0]    = core_c;
    src_cout[0] = core_cout;
    src_ovf[0]  = core_ovf;
    for (int k = 1; k < STAGES; k++) begin
      load[k]     = adv[k-1];
      src_c[k]    = c_p[k-1];
      src_cout[k] = cout_p[k-1];
      src_ovf[k]  = ovf_p[k-1];
    end
  end

  // Slot registers: data only moves on load, so a stalled slot holds its value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p  <= '0;
      cout_p <= '0;
      ovf_p  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        c_p[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush) begin
          vld_p[k] <= 1'b0;
        end else if (load[k]) begin
          vld_p[k] <= 1'b1;
        end else if (adv[k]) begin
          vld_p[k] <= 1'b0;
        end
        if (load[k]) begin
          c_p[k]    <= src_c[k];
          cout_p[k] <= src_cout[k];
          ovf_p[k]  <= src_ovf[k];
        end
      end
    end
  end

  // Output side: zero flag derived from the registered result, quiet when no result is held.
  assign out_valid = vld_p[STAGES-1];
  assign out_c     = c_p[STAGES-1];
  assign out_cout  = cout_p[STAGES-1];
  assign out_ovf   = ovf_p[STAGES-1];
  assign out_zero  = vld_p[STAGES-1] && (c_p[STAGES-1] == '0);

endmodule
